if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 67 ++++++
 tb/tb_if_id_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline slot: pairs synchronous program-memory data with its fetch
// address, captures that data across stalls, squashes on flush, counts bubbles.
module if_id_stage #(
  parameter int unsigned            ADDR_WIDTH  = 14,
  parameter int unsigned            INSTR_WIDTH = 16,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 16'h0000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  input  logic [INSTR_WIDTH-1:0] prog_mem_read_data,
  output logic [INSTR_WIDTH-1:0] id_instruction,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  output logic                   id_valid,
  output logic [15:0]            bubble_count
);

  localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

  logic [ADDR_WIDTH-1:0]  pend_pc;
  logic                   pend_valid;
  logic [INSTR_WIDTH-1:0] hold_instr;
  logic                   hold_valid;
  logic [INSTR_WIDTH-1:0] slot_data_c;

  // Memory output only lines up with pend_pc for one cycle; after that use the captured copy.
  assign slot_data_c = hold_valid ? hold_instr : prog_mem_read_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_pc        <= '0;
      pend_valid     <= 1'b0;
      hold_instr     <= NOP_INSTR;
      hold_valid     <= 1'b0;
      id_instruction <= NOP_INSTR;
      id_pc          <= '0;
      id_valid       <= 1'b0;
      bubble_count   <= '0;
    end else begin
      if (!id_valid && bubble_count != BUBBLE_MAX)
        bubble_count <= bubble_count + 16'd1;

      if (flush) begin
        // id_pc and pend_pc keep their values; only validity and data are squashed.
        pend_valid     <= 1'b0;
        hold_valid     <= 1'b0;
        id_valid       <= 1'b0;
        id_instruction <= NOP_INSTR;
      end else if (stall) begin
        if (pend_valid && !hold_valid) begin
          hold_instr <= prog_mem_read_data;
          hold_valid <= 1'b1;
        end
      end else begin
        pend_pc        <= fetch_addr;
        pend_valid     <= 1'b1;
        hold_valid     <= 1'b0;
        id_pc          <= pend_pc;
        id_valid       <= pend_valid;
        id_instruction <= pend_valid ? slot_data_c : NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: each issued fetch pushes its expected ID
// slot, which is popped and compared when the pipeline advances.
module tb_if_id_stage;

  localparam int unsigned AW = 14;
  localparam int unsigned IW = 16;
  localparam logic [IW-1:0] NOP = 16'h0000;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [IW-1:0] prog_mem_read_data = '0;
  logic [IW-1:0] id_instruction;
  logic [AW-1:0] id_pc;
  logic          id_valid;
  logic [15:0]   bubble_count;

  logic corrupt = 1'b0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
    logic          valid;
  } slot_t;

  slot_t         sb_q[$];
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_instr;
  logic          m_valid;
  logic [15:0]   m_bub;

  int vectors = 0;
  int miscompares = 0;

  if_id_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .NOP_INSTR(NOP)) dut (
    .clock              (clock),
    .reset              (reset),
    .stall              (stall),
    .flush              (flush),
    .fetch_addr         (fetch_addr),
    .prog_mem_read_data (prog_mem_read_data),
    .id_instruction     (id_instruction),
    .id_pc              (id_pc),
    .id_valid           (id_valid),
    .bubble_count       (bubble_count)
  );

  always #5 clock = ~clock;

  // Synchronous program memory: word at addr holds A000+addr unless corrupted.
  always @(posedge clock)
    prog_mem_read_data <= corrupt ? 16'hDEAD : IW'(16'hA000 + 16'(fetch_addr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(id_valid), 32'(m_valid));
    check({tag, ".pc"}, 32'(id_pc), 32'(m_pc));
    check({tag, ".instr"}, 32'(id_instruction), 32'(m_instr));
    check({tag, ".bubbles"}, 32'(bubble_count), 32'(m_bub));
  endtask

  task automatic model_reset();
    sb_q.delete();
    sb_q.push_back('{pc: '0, instr: NOP, valid: 1'b0});
    m_pc = '0; m_instr = NOP; m_valid = 1'b0; m_bub = '0;
  endtask

  // Drive one cycle's inputs, take the edge, update the scoreboard and compare.
  task automatic step(input string tag, input logic s, input logic f, input int addr);
    slot_t e;
    stall = s; flush = f; fetch_addr = AW'(addr);
    @(posedge clock);
    #1;
    if (!m_valid && m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
    if (f) begin
      sb_q[0].valid = 1'b0;
      sb_q[0].instr = NOP;
      m_valid = 1'b0;
      m_instr = NOP;
    end else if (!s) begin
      e = sb_q.pop_front();
      m_pc = e.pc; m_instr = e.instr; m_valid = e.valid;
      sb_q.push_back('{pc: AW'(addr), instr: IW'(16'hA000 + 16'(addr)), valid: 1'b1});
    end
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (expected finish)");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clock);
    #1;
    check_outputs("reset_held");
    reset = 1'b0;

    // Streaming from reset.
    for (int a = 0; a <= 6; a++) step("stream", 1'b0, 1'b0, a);

    // Stall with memory corrupted after the first stall edge; fetch PC frozen at 7.
    step("stall0", 1'b1, 1'b0, 7);
    corrupt = 1'b1;
    step("stall1", 1'b1, 1'b0, 7);
    step("stall2", 1'b1, 1'b0, 7);
    corrupt = 1'b0;
    step("release", 1'b0, 1'b0, 7);
    for (int a = 8; a <= 10; a++) step("after_stall", 1'b0, 1'b0, a);

    // Flush with id_pc=9, then redirect to 20.
    step("flush", 1'b0, 1'b1, 15);
    for (int a = 20; a <= 22; a++) step("redirect", 1'b0, 1'b0, a);

    // Stall and flush together behave as flush.
    step("stall_flush", 1'b1, 1'b1, 30);
    check("stall_flush.hold_valid", 32'(dut.hold_valid), 32'd0);
    for (int a = 31; a <= 33; a++) step("post_sf", 1'b0, 1'b0, a);

    // Asynchronous reset between edges while data is held.
    step("pre_reset_stall", 1'b1, 1'b0, 34);
    check("pre_reset.hold_valid", 32'(dut.hold_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    check("async_reset.hold_valid", 32'(dut.hold_valid), 32'd0);
    reset = 1'b0;

    // Four bubble edges under stall after reset, then streaming restart.
    for (int i = 0; i < 4; i++) step("bubble", 1'b1, 1'b0, 40);
    check("bubble_count4", 32'(bubble_count), 32'd4);
    for (int a = 40; a <= 43; a++) step("restart", 1'b0, 1'b0, a);

    // Saturation from a preloaded count.
    step("sat_flush", 1'b0, 1'b1, 50);
    force dut.bubble_count = 16'hFFFD;
    #1;
    release dut.bubble_count;
    m_bub = 16'hFFFD;
    for (int i = 0; i < 4; i++) step("saturate", 1'b1, 1'b0, 50);
    check("bubble_sat", 32'(bubble_count), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
